// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture path: active-low segment
// patterns (g..a), special digit codes and the scan-tracking FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG7_PAT_0     = 7'b1000000;
  localparam logic [6:0] SEG7_PAT_1     = 7'b1111001;
  localparam logic [6:0] SEG7_PAT_2     = 7'b0100100;
  localparam logic [6:0] SEG7_PAT_3     = 7'b0110000;
  localparam logic [6:0] SEG7_PAT_4     = 7'b0011001;
  localparam logic [6:0] SEG7_PAT_5     = 7'b0010010;
  localparam logic [6:0] SEG7_PAT_6     = 7'b0000010;
  localparam logic [6:0] SEG7_PAT_7     = 7'b1111000;
  localparam logic [6:0] SEG7_PAT_8     = 7'b0000000;
  localparam logic [6:0] SEG7_PAT_9     = 7'b0010000;
  localparam logic [6:0] SEG7_PAT_BLANK = 7'b1111111;

  localparam logic [3:0] SEG7_CODE_BLANK = 4'hF;
  localparam logic [3:0] SEG7_CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the BCD-to-segment encoder: maps an active-low
// segment pattern to a BCD code, F for blank, E (with invalid) otherwise.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  // Pattern lookup; anything not in the encoder table is flagged invalid.
  always_comb begin
    code    = SEG7_CODE_ERR;
    invalid = 1'b1;
    case (seg)
      SEG7_PAT_0:     begin code = 4'd0;            invalid = 1'b0; end
      SEG7_PAT_1:     begin code = 4'd1;            invalid = 1'b0; end
      SEG7_PAT_2:     begin code = 4'd2;            invalid = 1'b0; end
      SEG7_PAT_3:     begin code = 4'd3;            invalid = 1'b0; end
      SEG7_PAT_4:     begin code = 4'd4;            invalid = 1'b0; end
      SEG7_PAT_5:     begin code = 4'd5;            invalid = 1'b0; end
      SEG7_PAT_6:     begin code = 4'd6;            invalid = 1'b0; end
      SEG7_PAT_7:     begin code = 4'd7;            invalid = 1'b0; end
      SEG7_PAT_8:     begin code = 4'd8;            invalid = 1'b0; end
      SEG7_PAT_9:     begin code = 4'd9;            invalid = 1'b0; end
      SEG7_PAT_BLANK: begin code = SEG7_CODE_BLANK; invalid = 1'b0; end
      default:        begin code = SEG7_CODE_ERR;   invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed seven-segment bus: samples seg/an, waits for
// a stable one-hot pattern, decodes it and stores it per digit position.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    all_valid,
  output logic                    upd,
  output logic [IDX_W-1:0]        upd_idx,
  output logic                    err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [6:0]              seg_s_q, seg_p_q;
  logic [NUM_DIGITS-1:0]   an_s_q, an_p_q;
  seg7_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;

  logic [NUM_DIGITS-1:0]   an_low;
  logic                    one_hot;
  logic                    change;
  logic                    accept;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              dec_code;
  logic                    dec_invalid;

  seg7_pattern_decode u_decode (
    .seg     (seg_s_q),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  // Sample qualification: one-hot-low enable, bit position, and change vs previous sample.
  always_comb begin
    an_low  = ~an_s_q;
    one_hot = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    change  = (seg_s_q != seg_p_q) || (an_s_q != an_p_q);
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

  // Scan-tracking FSM: debounce counter and accept decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (one_hot) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (change) begin
          state_d = one_hot ? ST_SETTLE : ST_WAIT;
          cnt_d   = one_hot ? CNT_W'(1) : '0;
        end else if (cnt_q >= CNT_W'(STABLE_CYCLES)) begin
          accept  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (change) begin
          state_d = one_hot ? ST_SETTLE : ST_WAIT;
          cnt_d   = one_hot ? CNT_W'(1) : '0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture datapath: clear first, then an accepted digit overlays the cleared image.
  always_comb begin
    if (clr) begin
      digits_d = {NUM_DIGITS{SEG7_CODE_BLANK}};
      valid_d  = '0;
      err_d    = 1'b0;
    end else begin
      digits_d = digits_q;
      valid_d  = valid_q;
      err_d    = err_q;
    end
    upd_d     = accept;
    upd_idx_d = upd_idx_q;
    if (accept) begin
      digits_d[{idx, 2'b00} +: 4] = dec_code;
      valid_d[idx]                = 1'b1;
      err_d                       = err_d | dec_invalid;
      upd_idx_d                   = idx;
    end else begin
      upd_idx_d = upd_idx_q;
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s_q   <= 7'h7F;
      seg_p_q   <= 7'h7F;
      an_s_q    <= '1;
      an_p_q    <= '1;
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      digits_q  <= {NUM_DIGITS{SEG7_CODE_BLANK}};
      valid_q   <= '0;
      err_q     <= 1'b0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      seg_s_q   <= seg;
      seg_p_q   <= seg_s_q;
      an_s_q    <= an;
      an_p_q    <= an_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign digits    = digits_q;
  assign valid     = valid_q;
  assign all_valid = &valid_q;
  assign upd       = upd_q;
  assign upd_idx   = upd_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: directed scans push expected
// writes (index, code, cycle); a negedge monitor checks every upd pulse.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  localparam int ND  = 4;
  localparam int SC  = 4;
  localparam int LAT = SC + 2;

  logic          clk = 1'b0;
  logic          rst, clr;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [15:0]   digits;
  logic [ND-1:0] valid;
  logic          all_valid, upd, err;
  logic [1:0]    upd_idx;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an), .clr(clr),
    .digits(digits), .valid(valid), .all_valid(all_valid),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] i, input logic [3:0] c);
    exp_t e;
    e.idx  = i;
    e.code = c;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [ND-1:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
  endtask

  // Monitor: every upd pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (upd) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_upd: idx %0d code %0h at cycle %0d", upd_idx, digits[4*upd_idx +: 4], cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("upd_idx", upd_idx, e.idx);
        check("upd_code", digits[4*e.idx +: 4], e.code);
        check("upd_cycle", cyc, e.cyc);
        check("upd_valid_bit", valid[e.idx], 1'b1);
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; an = '1; seg = 7'h7F;
    tick(3);
    rst = 1'b0;
    check("rst_digits", digits, 16'hFFFF);
    check("rst_valid", valid, 4'h0);
    check("rst_err", err, 1'b0);
    check("rst_upd", upd, 1'b0);
    check("rst_upd_idx", upd_idx, 2'd0);
    tick(1);

    // Single digit '2' on position 0.
    drive(4'b1110, SEG7_PAT_2); push(2'd0, 4'd2);
    tick(12);
    check("t1_digit0", digits[3:0], 4'd2);
    check("t1_valid", valid, 4'b0001);
    check("t1_upd_idx", upd_idx, 2'd0);

    // Two scanner passes showing 1,9,0,blank; each dwell writes once.
    for (int pass = 0; pass < 2; pass++) begin
      drive(4'b1110, SEG7_PAT_1);     push(2'd0, 4'd1);  tick(8);
      drive(4'b1101, SEG7_PAT_9);     push(2'd1, 4'd9);  tick(8);
      drive(4'b1011, SEG7_PAT_0);     push(2'd2, 4'd0);  tick(8);
      drive(4'b0111, SEG7_PAT_BLANK); push(2'd3, 4'hF);  tick(8);
      check("scan_digits", digits, 16'hF091);
      check("scan_all_valid", all_valid, 1'b1);
    end

    // Glitch on digit 1: only the final stable '3' is written.
    drive(4'b1101, SEG7_PAT_2); tick(2);
    seg = SEG7_PAT_8;           tick(1);
    seg = SEG7_PAT_3;           push(2'd1, 4'd3);
    tick(12);
    check("glitch_digits", digits, 16'hF031);

    // Two enables low: never accepted.
    drive(4'b1100, SEG7_PAT_5);
    tick(20);
    check("multi_digits", digits, 16'hF031);
    check("multi_state", dut.state_q, ST_WAIT);

    // Invalid pattern on digit 2, sticky err, then clr.
    drive(4'b1011, 7'b0101010); push(2'd2, SEG7_CODE_ERR);
    tick(10);
    check("inv_digits", digits, 16'hFE31);
    check("inv_err", err, 1'b1);
    tick(5);
    check("inv_err_sticky", err, 1'b1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_err", err, 1'b0);
    check("clr_digits", digits, 16'hFFFF);
    check("clr_valid", valid, 4'h0);
    check("clr_all_valid", all_valid, 1'b0);

    // Populate digit 0, then clr coincident with accept of '7' on digit 3.
    drive(4'b1110, SEG7_PAT_4); push(2'd0, 4'd4);
    tick(10);
    check("pre_valid", valid, 4'b0001);
    drive(4'b0111, SEG7_PAT_7); push(2'd3, 4'd7);
    tick(LAT - 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clracc_valid", valid, 4'b1000);
    check("clracc_digits", digits, 16'h7FFF);
    check("clracc_upd_idx", upd_idx, 2'd3);

    // Reset during SETTLE: outputs return to reset values, no write.
    drive(4'b1110, SEG7_PAT_5);
    tick(3);
    check("settle_state", dut.state_q, ST_SETTLE);
    rst = 1'b1; tick(1);
    rst = 1'b0; drive(4'b1111, SEG7_PAT_BLANK);
    tick(10);
    check("rst2_digits", digits, 16'hFFFF);
    check("rst2_valid", valid, 4'h0);
    check("rst2_err", err, 1'b0);
    check("rst2_upd", upd, 1'b0);
    check("rst2_upd_idx", upd_idx, 2'd0);
    check("rst2_state", dut.state_q, ST_WAIT);

    tick(2);
    check("pending_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
